// File: rtl/multicycle_controller_if.sv
// Bundle of control and handshake signals between the multi-cycle controller
// and the datapath. The controller side uses the master modport, while the
// datapath (or a testbench standing in for it) uses the slave modport.
interface multicycle_controller_if;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;

  logic        mem_req;
  logic        mem_write;
  logic        iord;
  logic        ir_write;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  pc_src;
  logic        pc_en;
  logic        illegal_op;
  logic [3:0]  state;
  logic [15:0] retired;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_write, iord, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
           illegal_op, state, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_write, iord, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
           illegal_op, state, retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM. It steps a shared-memory, single-ALU datapath
// through fetch/decode/execute/memory/writeback, stalls on mem_ready and counts
// retired instructions.
// Optional feature macro: MC_ILLEGAL_TRAP_EN. When it is defined, an unknown
// opcode parks the FSM in TRAP with illegal_op raised until reset. When it is
// undefined, an unknown opcode retires as a NOP.
// Reset (rst) is asynchronous and active-low. While it is held low, every
// control output is forced to 0.
module multicycle_controller (
  input logic clk,
  input logic rst,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    CLS_MEM,
    CLS_RTYPE,
    CLS_ADDI,
    CLS_BEQ,
    CLS_JUMP,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t      state_q;
  state_t      state_d;
  op_class_t   op_class;
  logic        retire;
  logic [15:0] retired_q;

  logic        mem_req_raw;
  logic        mem_write_raw;
  logic        iord_raw;
  logic        ir_write_raw;
  logic        reg_write_raw;
  logic        reg_dst_raw;
  logic        mem_to_reg_raw;
  logic        alu_src_a_raw;
  logic [1:0]  alu_src_b_raw;
  logic [1:0]  alu_op_raw;
  logic [1:0]  pc_src_raw;
  logic        pc_write_raw;
  logic        branch_raw;
  logic        pc_en_raw;
  logic        illegal_raw;

  // Classify the IR opcode into the instruction families the FSM understands
  always_comb begin
    op_class = CLS_ILLEGAL;
    case (bus.opcode)
      OP_LW, OP_SW: op_class = CLS_MEM;
      OP_RTYPE:     op_class = CLS_RTYPE;
      OP_ADDI:      op_class = CLS_ADDI;
      OP_BEQ:       op_class = CLS_BEQ;
      OP_J:         op_class = CLS_JUMP;
      default:      op_class = CLS_ILLEGAL;
    endcase
  end

  // State register; reset drops straight back to FETCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; memory states hold until mem_ready
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op_class)
          CLS_MEM:   state_d = MEMADR;
          CLS_RTYPE: state_d = EXEC;
          CLS_ADDI:  state_d = ADDIEX;
          CLS_BEQ:   state_d = BRANCH;
          CLS_JUMP:  state_d = JUMP;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            state_d = TRAP;
`else
            state_d = FETCH;
`endif
          end
        endcase
      end
      MEMADR: state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = bus.mem_ready ? MEMWB : MEMRD;
      MEMWB:  state_d = FETCH;
      MEMWR:  state_d = bus.mem_ready ? FETCH : MEMWR;
      EXEC:   state_d = ALUWB;
      ALUWB:  state_d = FETCH;
      ADDIEX: state_d = ADDIWB;
      ADDIWB: state_d = FETCH;
      BRANCH: state_d = FETCH;
      JUMP:   state_d = FETCH;
      TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
        state_d = TRAP;
`else
        state_d = FETCH;
`endif
      end
      default: state_d = FETCH;
    endcase
  end

  // An instruction retires when we re-enter FETCH from real work (not a stall or the trap)
  always_comb begin
    retire = (state_d == FETCH) && (state_q != FETCH) && (state_q != TRAP);
  end

  // Retired-instruction counter, free-running wrap at 16 bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q <= 16'd0;
    end else if (retire) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  // Moore control decode from the current state; FETCH and BRANCH fold in mem_ready/zero
  always_comb begin
    mem_req_raw    = 1'b0;
    mem_write_raw  = 1'b0;
    iord_raw       = 1'b0;
    ir_write_raw   = 1'b0;
    reg_write_raw  = 1'b0;
    reg_dst_raw    = 1'b0;
    mem_to_reg_raw = 1'b0;
    alu_src_a_raw  = 1'b0;
    alu_src_b_raw  = 2'b00;
    alu_op_raw     = 2'b00;
    pc_src_raw     = 2'b00;
    pc_write_raw   = 1'b0;
    branch_raw     = 1'b0;
    illegal_raw    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req_raw   = 1'b1;
        alu_src_b_raw = 2'b01;
        ir_write_raw  = bus.mem_ready;
        pc_write_raw  = bus.mem_ready;
      end
      DECODE: begin
        alu_src_b_raw = 2'b11;
      end
      MEMADR: begin
        alu_src_a_raw = 1'b1;
        alu_src_b_raw = 2'b10;
      end
      MEMRD: begin
        mem_req_raw = 1'b1;
        iord_raw    = 1'b1;
      end
      MEMWB: begin
        reg_write_raw  = 1'b1;
        mem_to_reg_raw = 1'b1;
      end
      MEMWR: begin
        mem_req_raw   = 1'b1;
        mem_write_raw = 1'b1;
        iord_raw      = 1'b1;
      end
      EXEC: begin
        alu_src_a_raw = 1'b1;
        alu_op_raw    = 2'b10;
      end
      ALUWB: begin
        reg_write_raw = 1'b1;
        reg_dst_raw   = 1'b1;
      end
      ADDIEX: begin
        alu_src_a_raw = 1'b1;
        alu_src_b_raw = 2'b10;
      end
      ADDIWB: begin
        reg_write_raw = 1'b1;
      end
      BRANCH: begin
        alu_src_a_raw = 1'b1;
        alu_op_raw    = 2'b01;
        pc_src_raw    = 2'b01;
        branch_raw    = 1'b1;
      end
      JUMP: begin
        pc_src_raw   = 2'b10;
        pc_write_raw = 1'b1;
      end
      TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
        illegal_raw = 1'b1;
`else
        illegal_raw = 1'b0;
`endif
      end
      default: begin
        illegal_raw = 1'b0;
      end
    endcase
    pc_en_raw = pc_write_raw | (branch_raw & bus.zero);
  end

  // Output gating so reset kills every strobe (including an in-flight write) without waiting for a clock
  always_comb begin
    bus.mem_req    = rst & mem_req_raw;
    bus.mem_write  = rst & mem_write_raw;
    bus.iord       = rst & iord_raw;
    bus.ir_write   = rst & ir_write_raw;
    bus.reg_write  = rst & reg_write_raw;
    bus.reg_dst    = rst & reg_dst_raw;
    bus.mem_to_reg = rst & mem_to_reg_raw;
    bus.alu_src_a  = rst & alu_src_a_raw;
    bus.alu_src_b  = rst ? alu_src_b_raw : 2'b00;
    bus.alu_op     = rst ? alu_op_raw : 2'b00;
    bus.pc_src     = rst ? pc_src_raw : 2'b00;
    bus.pc_en      = rst & pc_en_raw;
    bus.illegal_op = rst & illegal_raw;
    bus.state      = state_q;
    bus.retired    = retired_q;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Instructions are described as
// phase lists per opcode family. The expected control word for each phase
// comes from a table, and retired is tracked as a simple instruction count.
// Building with MC_ILLEGAL_TRAP_EN also exercises the trap path.
module tb_multicycle_controller;

  localparam int P_FETCH  = 0;
  localparam int P_DECODE = 1;
  localparam int P_MEMADR = 2;
  localparam int P_MEMRD  = 3;
  localparam int P_MEMWB  = 4;
  localparam int P_MEMWR  = 5;
  localparam int P_EXEC   = 6;
  localparam int P_ALUWB  = 7;
  localparam int P_BRANCH = 8;
  localparam int P_ADDIEX = 9;
  localparam int P_ADDIWB = 10;
  localparam int P_JUMP   = 11;
  localparam int P_TRAP   = 12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ILL   = 6'b111111;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   wr_cycles = 0;
  logic [15:0] model_retired;

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  function automatic logic [15:0] observed_ctrl();
    return {bus.mem_req, bus.mem_write, bus.iord, bus.ir_write, bus.reg_write,
            bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
            bus.alu_op, bus.pc_src, bus.pc_en, bus.illegal_op};
  endfunction

  function automatic logic [15:0] exp_ctrl(input int ph, input bit rdy, input bit z);
    logic       mreq = 1'b0;
    logic       mwr  = 1'b0;
    logic       iord = 1'b0;
    logic       irw  = 1'b0;
    logic       rw   = 1'b0;
    logic       rd   = 1'b0;
    logic       m2r  = 1'b0;
    logic       asa  = 1'b0;
    logic [1:0] asb  = 2'b00;
    logic [1:0] aop  = 2'b00;
    logic [1:0] psrc = 2'b00;
    logic       pcen = 1'b0;
    logic       ill  = 1'b0;
    case (ph)
      P_FETCH:  begin mreq = 1'b1; asb = 2'b01; irw = rdy; pcen = rdy; end
      P_DECODE: begin asb = 2'b11; end
      P_MEMADR: begin asa = 1'b1; asb = 2'b10; end
      P_MEMRD:  begin mreq = 1'b1; iord = 1'b1; end
      P_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
      P_MEMWR:  begin mreq = 1'b1; mwr = 1'b1; iord = 1'b1; end
      P_EXEC:   begin asa = 1'b1; aop = 2'b10; end
      P_ALUWB:  begin rw = 1'b1; rd = 1'b1; end
      P_BRANCH: begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pcen = z; end
      P_ADDIEX: begin asa = 1'b1; asb = 2'b10; end
      P_ADDIWB: begin rw = 1'b1; end
      P_JUMP:   begin psrc = 2'b10; pcen = 1'b1; end
      P_TRAP:   begin ill = 1'b1; end
      default:  begin ill = 1'b0; end
    endcase
    return {mreq, mwr, iord, irw, rw, rd, m2r, asa, asb, aop, psrc, pcen, ill};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1: drive inputs, check mid-cycle, advance to next posedge+1
  task automatic apply_stimulus(input int ph, input bit rdy, input bit z, input string tag);
    bus.mem_ready = rdy;
    bus.zero      = z;
    #3;
    check_output({tag, "_state"}, 32'(bus.state), 32'(ph));
    check_output({tag, "_ctrl"}, 32'(observed_ctrl()), 32'(exp_ctrl(ph, rdy, z)));
    check_output({tag, "_retired"}, 32'(bus.retired), 32'(model_retired));
    if (bus.mem_write === 1'b1) wr_cycles++;
    @(posedge clk);
    #1;
  endtask

  // Run one instruction; negative stall counts mean random 0..2 stall cycles
  task automatic run_instr(input logic [5:0] op, input bit z, input int fetch_stall,
                           input int mem_stall, input string tag);
    int ph[$];
    int n;
    ph.push_back(P_FETCH);
    ph.push_back(P_DECODE);
    case (op)
      OP_LW:    begin ph.push_back(P_MEMADR); ph.push_back(P_MEMRD); ph.push_back(P_MEMWB); end
      OP_SW:    begin ph.push_back(P_MEMADR); ph.push_back(P_MEMWR); end
      OP_RTYPE: begin ph.push_back(P_EXEC); ph.push_back(P_ALUWB); end
      OP_ADDI:  begin ph.push_back(P_ADDIEX); ph.push_back(P_ADDIWB); end
      OP_BEQ:   ph.push_back(P_BRANCH);
      OP_J:     ph.push_back(P_JUMP);
      default:  n = 0;
    endcase
    bus.opcode = op;
    foreach (ph[i]) begin
      if (ph[i] == P_FETCH || ph[i] == P_MEMRD || ph[i] == P_MEMWR) begin
        n = (ph[i] == P_FETCH) ? fetch_stall : mem_stall;
        if (n < 0) n = int'($urandom_range(0, 2));
        repeat (n) apply_stimulus(ph[i], 1'b0, z, tag);
        apply_stimulus(ph[i], 1'b1, z, tag);
      end else begin
        apply_stimulus(ph[i], 1'($urandom_range(0, 1)), z, tag);
      end
    end
    model_retired = model_retired + 16'd1;
  endtask

  // Hold reset across a clock edge, check forced-zero outputs, release at posedge+1
  task automatic apply_reset(input string tag);
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b1;
    #2;
    model_retired = 16'd0;
    check_output({tag, "_ctrl"}, 32'(observed_ctrl()), 32'd0);
    check_output({tag, "_state"}, 32'(bus.state), 32'd0);
    check_output({tag, "_retired"}, 32'(bus.retired), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [5:0] legal_ops [6];
    logic [5:0] op;
    int         pick;
    legal_ops = '{OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J};

    rst = 1'b0;
    bus.opcode = OP_LW;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    model_retired = 16'd0;
    #12;
    check_output("reset_ctrl", 32'(observed_ctrl()), 32'd0);
    check_output("reset_state", 32'(bus.state), 32'd0);
    check_output("reset_retired", 32'(bus.retired), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    $display("[TB] lw with mem_ready tied high");
    run_instr(OP_LW, 1'b0, 0, 0, "lw");
    check_output("lw_retired_after", 32'(bus.retired), 32'd1);

    $display("[TB] sw with three stall cycles in MEMWR");
    wr_cycles = 0;
    run_instr(OP_SW, 1'b0, 0, 3, "sw_stall");
    check_output("sw_write_cycles", 32'(wr_cycles), 32'd4);

    $display("[TB] beq taken and not taken");
    run_instr(OP_BEQ, 1'b1, 0, 0, "beq_z1");
    run_instr(OP_BEQ, 1'b0, 0, 0, "beq_z0");
    run_instr(OP_RTYPE, 1'b0, 2, 0, "r_fetch_stall");
    run_instr(OP_ADDI, 1'b1, 0, 0, "addi");

    $display("[TB] unknown opcode");
`ifdef MC_ILLEGAL_TRAP_EN
    bus.opcode = OP_ILL;
    apply_stimulus(P_FETCH, 1'b1, 1'b0, "ill_fetch");
    apply_stimulus(P_DECODE, 1'b1, 1'b0, "ill_decode");
    repeat (10) apply_stimulus(P_TRAP, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "trap_hold");
    apply_reset("trap_reset");
`else
    run_instr(OP_ILL, 1'b0, 0, 0, "ill_nop");
`endif

    $display("[TB] random instruction stream");
    for (int k = 0; k < 150; k++) begin
`ifdef MC_ILLEGAL_TRAP_EN
      pick = int'($urandom_range(0, 5));
`else
      pick = int'($urandom_range(0, 6));
`endif
      if (pick < 6) begin
        op = legal_ops[pick];
      end else begin
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
      end
      run_instr(op, 1'($urandom_range(0, 1)), -1, -1, "rand");
    end

    $display("[TB] reset during MEMRD");
    bus.opcode = OP_LW;
    apply_stimulus(P_FETCH, 1'b1, 1'b0, "abort_fetch");
    apply_stimulus(P_DECODE, 1'b1, 1'b0, "abort_decode");
    apply_stimulus(P_MEMADR, 1'b1, 1'b0, "abort_memadr");
    bus.mem_ready = 1'b0;
    #2;
    check_output("abort_memrd_ctrl", 32'(observed_ctrl()), 32'(exp_ctrl(P_MEMRD, 1'b0, 1'b0)));
    rst = 1'b0;
    #1;
    check_output("abort_async_ctrl", 32'(observed_ctrl()), 32'd0);
    check_output("abort_async_state", 32'(bus.state), 32'd0);
    model_retired = 16'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_instr(OP_SW, 1'b0, 0, 1, "after_abort");
    check_output("after_abort_retired", 32'(bus.retired), 32'd1);

    $display("[TB] retired counter wrap");
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    model_retired = 16'hFFFF;
    run_instr(OP_J, 1'b0, 0, 0, "wrap_j");
    check_output("wrap_retired", 32'(bus.retired), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
